// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply / divide for the execute stage.
// Multiply uses shift-add over a double-width accumulator and divide uses
// restoring division. Both take WIDTH iterations, one per clock.
// Divide-by-zero takes a single-cycle shortcut that skips the iterations.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      iter_cnt;
  logic               op_q;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   operand_q;
  // Multiply: {partial product high, multiplier / product low}.
  // Divide:   {remainder, dividend / quotient}.
  // The extra (2*WIDTH+1)th bit only exists inside one iteration step,
  // so it is never stored.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;

  // Status flags are pure decodes of the state register.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One iteration of either algorithm, selected by the latched opcode.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
    shifted  = {acc_q, 1'b0};
    trial    = shifted[2*WIDTH:WIDTH] - {1'b0, operand_q};
    // trial[WIDTH] set means the subtraction borrowed, so restore.
    div_next = trial[WIDTH] ? shifted[2*WIDTH-1:0]
                            : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    acc_next = op_q ? div_next : mul_next;
  end

  // Control FSM, iteration counter, working registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      op_q        <= 1'b0;
      operand_q   <= '0;
      acc_q       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            iter_cnt <= '0;
            if (op && (operand_b == '0)) begin
              state       <= DONE;
              result_lo   <= '1;
              result_hi   <= operand_a;
              div_by_zero <= 1'b1;
            end else begin
              state     <= CALC;
              operand_q <= op ? operand_b : operand_a;
              acc_q     <= {{WIDTH{1'b0}}, (op ? operand_a : operand_b)};
            end
          end
        end
        CALC: begin
          acc_q    <= acc_next;
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER) begin
            state     <= DONE;
            result_lo <= acc_next[WIDTH-1:0];
            result_hi <= acc_next[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          state       <= IDLE;
          div_by_zero <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat;
  int          busy_cnt;
  logic [15:0] lo;
  logic [15:0] hi;
  logic        dbz;

  mul_div_unit #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one start and follow it to done. Cycle i is sampled 1 unit after
  // edge N+i-1, where N is the accepting edge. lat = -1 if done never came.
  task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                        output int lat_o, output int busy_o,
                        output logic [15:0] lo_o, output logic [15:0] hi_o, output logic dbz_o);
    @(negedge clk);
    start = 1'b1; op = op_i; operand_a = a_i; operand_b = b_i;
    @(posedge clk); #1;
    start = 1'b0; operand_a = 16'hDEAD; operand_b = 16'hBEEF;
    lat_o = -1; busy_o = 0; lo_o = '0; hi_o = '0; dbz_o = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_o++;
      if (done) begin
        lat_o = i; lo_o = result_lo; hi_o = result_hi; dbz_o = div_by_zero;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 1'b0; operand_a = 16'h1111; operand_b = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (result_lo !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_lo: got %h expected 0000", result_lo); end
    n_checks++; if (result_hi !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_hi: got %h expected 0000", result_hi); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    run_op(1'b0, 16'h00FF, 16'h0101, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d expected 17", lat); end
    n_checks++; if (busy_cnt != 17) begin n_fail++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 17", busy_cnt); end
    n_checks++; if (lo !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL mul_ff_lo: got %h expected ffff", lo); end
    n_checks++; if (hi !== 16'h0000) begin n_fail++; $display("[TB] FAIL mul_ff_hi: got %h expected 0000", hi); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_dbz: got %b expected 0", dbz); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_done_pulse: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_busy_after: got %b expected 0", busy); end
    n_checks++; if (result_lo !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL mul_hold_lo: got %h expected ffff", result_lo); end
  endtask

  task automatic test_mul_edges();
    run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lo !== 16'h0001) begin n_fail++; $display("[TB] FAIL mul_max_lo: got %h expected 0001", lo); end
    n_checks++; if (hi !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL mul_max_hi: got %h expected fffe", hi); end
    run_op(1'b0, 16'h0000, 16'h1234, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lo !== 16'h0000) begin n_fail++; $display("[TB] FAIL mul_zero_lo: got %h expected 0000", lo); end
    n_checks++; if (hi !== 16'h0000) begin n_fail++; $display("[TB] FAIL mul_zero_hi: got %h expected 0000", hi); end
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL mul_zero_latency: got %0d expected 17", lat); end
  endtask

  task automatic test_div();
    run_op(1'b1, 16'hABCD, 16'h0010, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lo !== 16'h0ABC) begin n_fail++; $display("[TB] FAIL div_quot: got %h expected 0abc", lo); end
    n_checks++; if (hi !== 16'h000D) begin n_fail++; $display("[TB] FAIL div_rem: got %h expected 000d", hi); end
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL div_latency: got %0d expected 17", lat); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("[TB] FAIL div_dbz: got %b expected 0", dbz); end
    run_op(1'b1, 16'h0005, 16'h0007, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lo !== 16'h0000) begin n_fail++; $display("[TB] FAIL div_small_quot: got %h expected 0000", lo); end
    n_checks++; if (hi !== 16'h0005) begin n_fail++; $display("[TB] FAIL div_small_rem: got %h expected 0005", hi); end
  endtask

  task automatic test_div_by_zero();
    run_op(1'b1, 16'h1234, 16'h0000, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lat != 1) begin n_fail++; $display("[TB] FAIL dbz_latency: got %0d expected 1", lat); end
    n_checks++; if (busy_cnt != 1) begin n_fail++; $display("[TB] FAIL dbz_busy_cycles: got %0d expected 1", busy_cnt); end
    n_checks++; if (lo !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL dbz_lo: got %h expected ffff", lo); end
    n_checks++; if (hi !== 16'h1234) begin n_fail++; $display("[TB] FAIL dbz_hi: got %h expected 1234", hi); end
    n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("[TB] FAIL dbz_flag: got %b expected 1", dbz); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL dbz_flag_clear: got %b expected 0", div_by_zero); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL dbz_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_start_while_busy();
    lat = -1; lo = '0; hi = '0;
    @(negedge clk);
    start = 1'b1; op = 1'b1; operand_a = 16'h00C8; operand_b = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 1'b0; operand_a = 16'hFFFF; operand_b = 16'hFFFF;
      end
      if (i == 6) start = 1'b0;
      if (done) begin
        lat = i; lo = result_lo; hi = result_hi;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL ignore_latency: got %0d expected 17", lat); end
    n_checks++; if (lo !== 16'h0042) begin n_fail++; $display("[TB] FAIL ignore_quot: got %h expected 0042", lo); end
    n_checks++; if (hi !== 16'h0002) begin n_fail++; $display("[TB] FAIL ignore_rem: got %h expected 0002", hi); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_not_queued: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    int done_seen;
    @(negedge clk);
    start = 1'b1; op = 1'b0; operand_a = 16'h1234; operand_b = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    n_checks++; if (result_lo !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_lo: got %h expected 0000", result_lo); end
    n_checks++; if (result_hi !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_hi: got %h expected 0000", result_hi); end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_seen); end
    run_op(1'b0, 16'h0003, 16'h0005, lat, busy_cnt, lo, hi, dbz);
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL abort_restart_latency: got %0d expected 17", lat); end
    n_checks++; if (lo !== 16'h000F) begin n_fail++; $display("[TB] FAIL abort_restart_lo: got %h expected 000f", lo); end
    n_checks++; if (hi !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_restart_hi: got %h expected 0000", hi); end
  endtask

  task automatic test_back_to_back();
    lat = -1;
    @(negedge clk);
    start = 1'b1; op = 1'b0; operand_a = 16'h0002; operand_b = 16'h0003;
    @(posedge clk); #1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL b2b_first_latency: got %0d expected 17", lat); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_gap: got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL b2b_second_latency: got %0d expected 17", lat); end
    n_checks++; if (result_lo !== 16'h0006) begin n_fail++; $display("[TB] FAIL b2b_second_lo: got %h expected 0006", result_lo); end
    @(posedge clk); #1;
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
    test_reset();
    test_mul_basic();
    test_mul_edges();
    test_div();
    test_div_by_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
